uart_frame_transmitter: RTL and testbench

// UART TX serializer directly downstream of the UART transmitter controller.
// - Accepts one parallel byte per handshake.
// - Frames it as start bit, LSB-first data, optional parity and stop bit(s).
// - Drives the TX pin on the transmitter clock (one clock = one bit period).
// - Reports busy back to the controller, which synchronizes it into the reference clock domain.

---
 rtl/uart_frame_transmitter.sv | 118 +++++++++++
 tb/tb_uart_frame_transmitter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_transmitter.sv
// UART TX serializer: frames one parallel byte as start, LSB-first data, optional
// parity and stop bit(s), one bit per transmitter clock, with a registered busy flag.
module uart_frame_transmitter #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] parallel_data,
  input  logic                  parallel_data_valid,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic                  serial_data,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStopBits
    $error("uart_frame_transmitter: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic                    stop_cnt_q;
  logic                    par_en_q;
  logic                    par_acc_q;
  logic                    serial_q;
  logic                    busy_q;

  // The parity accumulator starts at the latched parity type and absorbs every
  // data bit as it leaves, so it holds ^data (even) or ~^data (odd) by PARITY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_acc_q  <= 1'b0;
      serial_q   <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          serial_q <= 1'b1;
          busy_q   <= 1'b0;
          if (parallel_data_valid) begin
            shift_q   <= parallel_data;
            par_en_q  <= parity_enable;
            par_acc_q <= parity_type;
            serial_q  <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          serial_q  <= shift_q[0];
          par_acc_q <= par_acc_q ^ shift_q[0];
          shift_q   <= shift_q >> 1;
          bit_cnt_q <= '0;
          state_q   <= DATA;
        end
        DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            stop_cnt_q <= 1'b0;
            if (par_en_q) begin
              serial_q <= par_acc_q;
              state_q  <= PARITY;
            end else begin
              serial_q <= 1'b1;
              state_q  <= STOP;
            end
          end else begin
            serial_q  <= shift_q[0];
            par_acc_q <= par_acc_q ^ shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end
        end
        PARITY: begin
          serial_q   <= 1'b1;
          stop_cnt_q <= 1'b0;
          state_q    <= STOP;
        end
        STOP: begin
          serial_q <= 1'b1;
          if (stop_cnt_q == LAST_STOP) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            stop_cnt_q <= 1'b1;
          end
        end
        default: begin
          serial_q <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign serial_data = serial_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_transmitter.sv
// Directed bench for uart_frame_transmitter: one-stop and two-stop instances
// driven in parallel from a table of frames plus hand-written corner sequences.
module tb_uart_frame_transmitter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] parallelData;
  logic       parallelDataValid;
  logic       parityEnable;
  logic       parityType;
  logic       serial1, busy1;
  logic       serial2, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_frame_transmitter #(.DATA_WIDTH(8), .STOP_BITS(1)) dutOneStop (
    .clk                 (clk),
    .reset               (reset),
    .parallel_data       (parallelData),
    .parallel_data_valid (parallelDataValid),
    .parity_enable       (parityEnable),
    .parity_type         (parityType),
    .serial_data         (serial1),
    .busy                (busy1)
  );

  uart_frame_transmitter #(.DATA_WIDTH(8), .STOP_BITS(2)) dutTwoStop (
    .clk                 (clk),
    .reset               (reset),
    .parallel_data       (parallelData),
    .parallel_data_valid (parallelDataValid),
    .parity_enable       (parityEnable),
    .parity_type         (parityType),
    .serial_data         (serial2),
    .busy                (busy2)
  );

  // seq lists line values left to right starting with the start bit, for one stop bit.
  typedef struct {
    logic [7:0]  data;
    logic        parEn;
    logic        parType;
    int          len;
    logic [15:0] seq;
  } vector_t;

  vector_t vectors[6];

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, actual, expected);
    end
  endtask

  // Called on a negedge; returns on the negedge right after the accepting posedge.
  task automatic applyStimulus(input logic [7:0] data, input logic pe, input logic pt);
    parallelData      = data;
    parityEnable      = pe;
    parityType        = pt;
    parallelDataValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset             = 1'b1;
    parallelDataValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [23:0] expLine;
    logic [23:0] expBusy;
    reset             = 1'b1;
    parallelData      = '0;
    parallelDataValid = 1'b0;
    parityEnable      = 1'b0;
    parityType        = 1'b0;

    vectors[0] = '{8'hA5, 1'b1, 1'b0, 11, 16'(11'b01010010101)};
    vectors[1] = '{8'h79, 1'b1, 1'b1, 11, 16'(11'b01001111001)};
    vectors[2] = '{8'h79, 1'b1, 1'b0, 11, 16'(11'b01001111011)};
    vectors[3] = '{8'hE7, 1'b0, 1'b0, 10, 16'(10'b0111001111)};
    vectors[4] = '{8'h00, 1'b1, 1'b1, 11, 16'(11'b00000000011)};
    vectors[5] = '{8'hFF, 1'b0, 1'b1, 10, 16'(10'b0111111111)};

    doReset();
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("reset idle serial c%0d", c), serial1, 1'b1);
      checkOutput($sformatf("reset idle busy c%0d", c), busy1, 1'b0);
      checkOutput($sformatf("reset idle busy2 c%0d", c), busy2, 1'b0);
      @(negedge clk);
    end

    // Table of whole frames, both stop-bit variants compared cycle by cycle.
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vectors[v].data, vectors[v].parEn, vectors[v].parType);
      parallelDataValid = 1'b0;
      for (int i = 0; i <= vectors[v].len + 1; i++) begin
        if (i < vectors[v].len) begin
          checkOutput($sformatf("v%0d s1 line c%0d", v, i), serial1, vectors[v].seq[vectors[v].len - 1 - i]);
          checkOutput($sformatf("v%0d s1 busy c%0d", v, i), busy1, 1'b1);
        end else begin
          checkOutput($sformatf("v%0d s1 idle line c%0d", v, i), serial1, 1'b1);
          checkOutput($sformatf("v%0d s1 idle busy c%0d", v, i), busy1, 1'b0);
        end
        if (i < vectors[v].len) begin
          checkOutput($sformatf("v%0d s2 line c%0d", v, i), serial2, vectors[v].seq[vectors[v].len - 1 - i]);
          checkOutput($sformatf("v%0d s2 busy c%0d", v, i), busy2, 1'b1);
        end else if (i == vectors[v].len) begin
          checkOutput($sformatf("v%0d s2 stop2 line", v), serial2, 1'b1);
          checkOutput($sformatf("v%0d s2 stop2 busy", v), busy2, 1'b1);
        end else begin
          checkOutput($sformatf("v%0d s2 idle busy", v), busy2, 1'b0);
          checkOutput($sformatf("v%0d s2 idle line", v), serial2, 1'b1);
        end
        @(negedge clk);
      end
    end

    // Reset in the middle of the data bits abandons the frame.
    applyStimulus(8'hA5, 1'b1, 1'b0);
    parallelDataValid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset line", serial1, 1'b1);
    checkOutput("midreset busy", busy1, 1'b0);
    checkOutput("midreset busy2", busy2, 1'b0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("after reset line c%0d", c), serial1, 1'b1);
      checkOutput($sformatf("after reset busy c%0d", c), busy1, 1'b0);
    end

    // Valid held high with data changed mid-frame: A5 completes, 3C follows after one idle cycle.
    doReset();
    applyStimulus(8'hA5, 1'b1, 1'b0);
    parallelData = 8'h3C;
    expLine = {11'b01010010101, 1'b1, 11'b00011110001, 1'b1};
    expBusy = {11'h7FF, 1'b0, 11'h7FF, 1'b0};
    for (int i = 0; i < 24; i++) begin
      if (i == 14) parallelDataValid = 1'b0;
      checkOutput($sformatf("backtoback line c%0d", i), serial1, expLine[23 - i]);
      checkOutput($sformatf("backtoback busy c%0d", i), busy1, expBusy[23 - i]);
      @(negedge clk);
    end

    // Parity controls toggled after acceptance must not change the frame.
    doReset();
    applyStimulus(8'h79, 1'b1, 1'b0);
    parallelDataValid = 1'b0;
    parityType   = 1'b1;
    parityEnable = 1'b0;
    expLine = 24'(11'b01001111011);
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin
        parityEnable = 1'b1;
        parityType   = 1'b0;
      end
      if (i == 7) parityType = 1'b1;
      if (i < 11) begin
        checkOutput($sformatf("partoggle line c%0d", i), serial1, expLine[10 - i]);
        checkOutput($sformatf("partoggle busy c%0d", i), busy1, 1'b1);
      end else begin
        checkOutput("partoggle end busy", busy1, 1'b0);
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
